// File: rtl/bip_datapath.sv
// bip_datapath: execution datapath of the BIP single-cycle CPU.
// Holds the accumulator and the data RAM, sign-extends the instruction
// immediate and runs the add/sub ALU. One instruction retires per i_valid
// cycle; o_acc and the flags are registered and update one clock later.
// Optional status flags are enabled by defining BIP_DATAPATH_FLAGS_EN;
// without it o_zero/o_neg/o_ovf are tied low and no flag state exists.
module bip_datapath #(
  parameter int NB_DATA          = 16,
  parameter int NB_OPERAND       = 11,
  parameter int N_DATA_ADDR      = 1024,
  parameter int LOG2_N_DATA_ADDR = 10
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic [1:0]            i_sel_a,
  input  logic                  i_sel_b,
  input  logic                  i_wr_acc,
  input  logic                  i_op_code,
  input  logic                  i_wr_ram,
  input  logic                  i_rd_ram,
  input  logic [NB_OPERAND-1:0] i_operand,
  output logic [NB_DATA-1:0]    o_acc,
  output logic                  o_zero,
  output logic                  o_neg,
  output logic                  o_ovf
);

  typedef enum logic [1:0] {
    SEL_RAM  = 2'b00,
    SEL_IMM  = 2'b01,
    SEL_ALU  = 2'b10,
    SEL_HOLD = 2'b11
  } sel_a_e;

  localparam int MSB = NB_DATA - 1;

  sel_a_e                      sel_a;
  logic [LOG2_N_DATA_ADDR-1:0] addr;
  logic [NB_DATA-1:0]          imm;
  logic [NB_DATA-1:0]          ram_q;
  logic [NB_DATA-1:0]          op_b;
  logic [NB_DATA-1:0]          alu;
  logic [NB_DATA-1:0]          acc_q;
  logic [NB_DATA-1:0]          acc_next;
  logic                        acc_we;
  logic                        ram_we;

  logic [NB_DATA-1:0] ram [N_DATA_ADDR];

  assign sel_a  = sel_a_e'(i_sel_a);
  // Upper operand bits are ignored for addressing, so addresses wrap.
  assign addr   = i_operand[LOG2_N_DATA_ADDR-1:0];
  assign imm    = {{(NB_DATA-NB_OPERAND){i_operand[NB_OPERAND-1]}}, i_operand};
  // Asynchronous read sees the pre-edge word, so a same-cycle store returns old data.
  assign ram_q  = i_rd_ram ? ram[addr] : '0;
  assign op_b   = i_sel_b ? imm : ram_q;
  assign alu    = i_op_code ? (acc_q + op_b) : (acc_q - op_b);
  assign acc_we = i_valid & i_wr_acc & (sel_a != SEL_HOLD);
  assign ram_we = i_valid & i_wr_ram & ~i_reset;
  assign o_acc  = acc_q;

  // Select the value the accumulator would take on a qualifying write.
  always_comb begin
    // NOTE: default assigned first so every path drives acc_next and no latch is inferred.
    acc_next = acc_q;
    unique case (sel_a)
      SEL_RAM:  acc_next = ram_q;
      SEL_IMM:  acc_next = imm;
      SEL_ALU:  acc_next = alu;
      SEL_HOLD: acc_next = acc_q;
    endcase
  end

  // Accumulator register; reset wins over i_valid.
  always_ff @(posedge i_clock) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (i_reset)     acc_q <= '0;
    else if (acc_we) acc_q <= acc_next;
  end

  // Data RAM store of the pre-edge accumulator; a store in a reset cycle is dropped.
  always_ff @(posedge i_clock) begin
    // NOTE: the RAM array is deliberately not reset so it maps onto plain memory.
    if (ram_we) ram[addr] <= acc_q;
  end

`ifdef BIP_DATAPATH_FLAGS_EN
  logic zero_q;
  logic neg_q;
  logic ovf_q;
  logic alu_ovf;

  // Signed overflow: add of like signs, or subtract of unlike signs, flipping acc's sign.
  assign alu_ovf = (alu[MSB] != acc_q[MSB]) &
                   (i_op_code ? (acc_q[MSB] == op_b[MSB]) : (acc_q[MSB] != op_b[MSB]));

  // Status flags track the most recent accumulator write.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      zero_q <= 1'b1;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (acc_we) begin
      zero_q <= (acc_next == '0);
      neg_q  <= acc_next[MSB];
      ovf_q  <= (sel_a == SEL_ALU) & alu_ovf;
    end
  end

  assign o_zero = zero_q;
  assign o_neg  = neg_q;
  assign o_ovf  = ovf_q;
`else
  assign o_zero = 1'b0;
  assign o_neg  = 1'b0;
  assign o_ovf  = 1'b0;
`endif

endmodule
